// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the MIPS pipeline control unit: FSM state encodings,
// the hard-wired zero register index and the default counter width.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_HALTED    = 3'd4
  } state_t;

  localparam logic [4:0] REG_ZERO      = 5'd0;
  localparam int         DEFAULT_CNT_W = 32;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detection and priority resolution against a taken
// branch; every output is gated by the global pipe enable.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       enable,
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       if_id_uses_rt,
  input  logic       ex_taken,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush
);

  logic lu;

  assign lu = id_ex_mem_read && (id_ex_rt != REG_ZERO) &&
              ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));

  // A taken branch squashes the dependent instruction, so it outranks the stall.
  always_comb begin
    pc_write    = 1'b0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (enable) begin
      if (ex_taken) begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        id_ex_flush = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_control_unit.sv
// Pipeline sequencer: run/step/halt FSM, hazard controls and debug counters.
// Counters exist only when PIPE_CTRL_PERF_CNT_EN is defined, otherwise tied to 0.
module pipeline_control_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step_mode,
  input  logic             i_step,
  input  logic             i_ID_EX_MemRead,
  input  logic [4:0]       i_ID_EX_Rt,
  input  logic [4:0]       i_IF_ID_Rs,
  input  logic [4:0]       i_IF_ID_Rt,
  input  logic             i_IF_ID_uses_rt,
  input  logic             i_EX_taken,
  input  logic             i_WB_stop_pipe,
  output logic             o_pipe_enable,
  output logic             o_pc_write,
  output logic             o_IF_ID_write,
  output logic             o_IF_ID_flush,
  output logic             o_ID_EX_flush,
  output logic             o_halted,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_stall_count
);

  state_t state;
  logic   halted_q;

  // The halt instruction in WB must freeze the pipe in the same cycle.
  assign o_pipe_enable = ((state == ST_RUN) || (state == ST_STEP_EXEC)) && !i_WB_stop_pipe;
  assign o_state       = state;
  assign o_halted      = halted_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      halted_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start) state <= i_step_mode ? ST_STEP_WAIT : ST_RUN;
        end
        ST_RUN: begin
          if (i_WB_stop_pipe) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end
        end
        ST_STEP_WAIT: begin
          if (i_step) state <= ST_STEP_EXEC;
        end
        ST_STEP_EXEC: begin
          if (i_WB_stop_pipe) begin
            state    <= ST_HALTED;
            halted_q <= 1'b1;
          end else begin
            state <= ST_STEP_WAIT;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  hazard_detect u_hazard (
    .enable         (o_pipe_enable),
    .id_ex_mem_read (i_ID_EX_MemRead),
    .id_ex_rt       (i_ID_EX_Rt),
    .if_id_rs       (i_IF_ID_Rs),
    .if_id_rt       (i_IF_ID_Rt),
    .if_id_uses_rt  (i_IF_ID_uses_rt),
    .ex_taken       (i_EX_taken),
    .pc_write       (o_pc_write),
    .if_id_write    (o_IF_ID_write),
    .if_id_flush    (o_IF_ID_flush),
    .id_ex_flush    (o_ID_EX_flush)
  );

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] stall_q;

  // A bubble without an IF/ID flush can only be a load-use stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cycle_q <= '0;
      stall_q <= '0;
    end else if (o_pipe_enable) begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (o_ID_EX_flush && !o_IF_ID_flush) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign o_cycle_count = cycle_q;
  assign o_stall_count = stall_q;
`else
  assign o_cycle_count = '0;
  assign o_stall_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Self-checking bench for pipeline_control_unit: directed and randomized steps
// compared every cycle against a behavioural model of the sequencer.
module tb_pipeline_control_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start, i_step_mode, i_step;
  logic        i_ID_EX_MemRead;
  logic [4:0]  i_ID_EX_Rt, i_IF_ID_Rs, i_IF_ID_Rt;
  logic        i_IF_ID_uses_rt, i_EX_taken, i_WB_stop_pipe;
  logic        o_pipe_enable, o_pc_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_flush;
  logic        o_halted;
  logic [2:0]  o_state;
  logic [31:0] o_cycle_count, o_stall_count;

  int vectors     = 0;
  int miscompares = 0;

  // Model: mode 0 idle, 1 run, 2 waiting for a step, 3 executing a step, 4 halted
  int          m_mode  = 0;
  bit          m_known = 1'b0;
  logic [31:0] m_cycles = '0;
  logic [31:0] m_stalls = '0;

  always #5 clk = ~clk;

  pipeline_control_unit #(.CNT_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_start         (i_start),
    .i_step_mode     (i_step_mode),
    .i_step          (i_step),
    .i_ID_EX_MemRead (i_ID_EX_MemRead),
    .i_ID_EX_Rt      (i_ID_EX_Rt),
    .i_IF_ID_Rs      (i_IF_ID_Rs),
    .i_IF_ID_Rt      (i_IF_ID_Rt),
    .i_IF_ID_uses_rt (i_IF_ID_uses_rt),
    .i_EX_taken      (i_EX_taken),
    .i_WB_stop_pipe  (i_WB_stop_pipe),
    .o_pipe_enable   (o_pipe_enable),
    .o_pc_write      (o_pc_write),
    .o_IF_ID_write   (o_IF_ID_write),
    .o_IF_ID_flush   (o_IF_ID_flush),
    .o_ID_EX_flush   (o_ID_EX_flush),
    .o_halted        (o_halted),
    .o_state         (o_state),
    .o_cycle_count   (o_cycle_count),
    .o_stall_count   (o_stall_count)
  );

  function automatic bit modelEnable();
    return ((m_mode == 1) || (m_mode == 3)) && !i_WB_stop_pipe;
  endfunction

  function automatic bit modelLoadUse();
    return i_ID_EX_MemRead && (i_ID_EX_Rt != 5'd0) &&
           ((i_ID_EX_Rt == i_IF_ID_Rs) || (i_IF_ID_uses_rt && (i_ID_EX_Rt == i_IF_ID_Rt)));
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Compares every output with the model, sampled mid-cycle away from the edge.
  task automatic checkOutput();
    bit en, lu, tk;
    logic [31:0] exp_cyc, exp_stl;
    if (!m_known) return;
    en = modelEnable();
    lu = modelLoadUse();
    tk = i_EX_taken;
`ifdef PIPE_CTRL_PERF_CNT_EN
    exp_cyc = m_cycles;
    exp_stl = m_stalls;
`else
    exp_cyc = '0;
    exp_stl = '0;
`endif
    chk("pipe_enable", 32'(o_pipe_enable), 32'(en));
    chk("pc_write",    32'(o_pc_write),    32'(en && (tk || !lu)));
    if (!(en && tk)) chk("IF_ID_write", 32'(o_IF_ID_write), 32'(en && !lu));
    chk("IF_ID_flush", 32'(o_IF_ID_flush), 32'(en && tk));
    chk("ID_EX_flush", 32'(o_ID_EX_flush), 32'(en && (tk || lu)));
    chk("halted",      32'(o_halted),      32'(m_mode == 4));
    chk("state",       32'(o_state),       32'(m_mode));
    chk("cycle_count", o_cycle_count,      exp_cyc);
    chk("stall_count", o_stall_count,      exp_stl);
  endtask

  task automatic modelAdvance();
    bit en, lu;
    en = modelEnable();
    lu = modelLoadUse();
    if (!rst) begin
      m_mode   = 0;
      m_cycles = '0;
      m_stalls = '0;
      m_known  = 1'b1;
    end else if (m_known) begin
      if (en) begin
        m_cycles = m_cycles + 32'd1;
        if (lu && !i_EX_taken) m_stalls = m_stalls + 32'd1;
      end
      case (m_mode)
        0: if (i_start) m_mode = i_step_mode ? 2 : 1;
        1: if (i_WB_stop_pipe) m_mode = 4;
        2: if (i_step) m_mode = 3;
        3: m_mode = i_WB_stop_pipe ? 4 : 2;
        default: m_mode = 4;
      endcase
    end
  endtask

  task automatic applyStimulus(input bit r, input bit st, input bit sm, input bit stp,
                               input bit mr, input logic [4:0] ert, input logic [4:0] rs,
                               input logic [4:0] rt, input bit ur, input bit tk, input bit stop);
    rst = r; i_start = st; i_step_mode = sm; i_step = stp;
    i_ID_EX_MemRead = mr; i_ID_EX_Rt = ert; i_IF_ID_Rs = rs; i_IF_ID_Rt = rt;
    i_IF_ID_uses_rt = ur; i_EX_taken = tk; i_WB_stop_pipe = stop;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    modelAdvance();
    #1;
  endtask

  task automatic randomStep(input bit sm);
    applyStimulus(1'b1, 1'b0, sm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), 1'b0);
  endtask

  initial begin
    applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // continuous run, ten enabled cycles
    applyStimulus(1'b1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 0, 0, 0);
    chk("cycle_after_10", o_cycle_count,
`ifdef PIPE_CTRL_PERF_CNT_EN
        32'd10
`else
        32'd0
`endif
    );

    // load-use on rs, on rt, against r0, and shadowed by a taken branch
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 1, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd9, 5'd3, 5'd9, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd8, 5'd8, 5'd8, 1, 1, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 5'd8, 5'd8, 5'd8, 1, 1, 0);

    for (int i = 0; i < 150; i++) randomStep(1'b0);

    // halt from RUN; start and step are then ignored
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 1);
    applyStimulus(1'b1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
    applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    // single-step mode: three pulses spaced four cycles apart
    applyStimulus(1'b1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
      for (int j = 0; j < 3; j++) applyStimulus(1'b1, 0, 1, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0);
    end
    chk("step_cycles", o_cycle_count,
`ifdef PIPE_CTRL_PERF_CNT_EN
        32'd3
`else
        32'd0
`endif
    );

    for (int i = 0; i < 80; i++) randomStep(1'b1);

    // halt arriving during a step execution
    applyStimulus(1'b1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 1);
    applyStimulus(1'b1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);

    applyStimulus(1'b0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(1'b1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
    chk("reset_cycle", o_cycle_count, 32'd0);
    chk("reset_state", 32'(o_state), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
